// File: rtl/data_memory.sv
// RV32I data memory stage: combinational byte/half/word loads, byte-enabled stores.
// Optional fault detection and sticky fault capture enabled by DMEM_FAULT_EN.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic [1:0]  FaultCause,
  output logic [31:0] FaultAddr,
  input  logic        FaultClr
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  size_e             ld_sz;
  size_e             st_sz;
  logic              fault_now;
  logic              st_en;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign idx  = Addr[ADDR_W+1:2];
  assign lane = Addr[1:0];

  // Access size decode; undefined encodings fall through to word.
  always_comb begin
    ld_sz = SZ_W;
    st_sz = SZ_W;
    case (Funct3)
      3'b000, 3'b100: ld_sz = SZ_B;
      3'b001, 3'b101: ld_sz = SZ_H;
      default:        ld_sz = SZ_W;
    endcase
    case (Funct3)
      3'b000:  st_sz = SZ_B;
      3'b001:  st_sz = SZ_H;
      default: st_sz = SZ_W;
    endcase
  end

`ifdef DMEM_FAULT_EN
  logic       ld_illegal;
  logic       st_illegal;
  logic       oor;
  logic       mis;
  logic [1:0] cause_now;
  logic       fault_q;
  logic [1:0] cause_q;
  logic [31:0] addr_q;

  // Fault classification with illegal > out of range > misaligned priority.
  always_comb begin
    ld_illegal = MemRead  && ((Funct3 == 3'b011) || (Funct3[2:1] == 2'b11));
    st_illegal = MemWrite && (Funct3[2] || (Funct3[1:0] == 2'b11));
    oor        = |Addr[31:ADDR_W+2];
    mis        = (MemRead  && (((ld_sz == SZ_H) && Addr[0]) || ((ld_sz == SZ_W) && (|Addr[1:0])))) ||
                 (MemWrite && (((st_sz == SZ_H) && Addr[0]) || ((st_sz == SZ_W) && (|Addr[1:0]))));
    cause_now  = 2'b00;
    if (ld_illegal || st_illegal) cause_now = 2'b11;
    else if (oor)                 cause_now = 2'b10;
    else if (mis)                 cause_now = 2'b01;
    fault_now  = (MemRead || MemWrite) && (cause_now != 2'b00);
  end

  // Sticky capture; a coincident clear lets a new fault overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      addr_q  <= 32'h0;
    end else if (fault_now && (!fault_q || FaultClr)) begin
      fault_q <= 1'b1;
      cause_q <= cause_now;
      addr_q  <= Addr;
    end else if (FaultClr) begin
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      addr_q  <= 32'h0;
    end
  end

  assign Fault      = fault_q;
  assign FaultCause = cause_q;
  assign FaultAddr  = addr_q;
`else
  logic unused_ok;

  // Without fault logic, alignment is implicit in the lane decode and high bits wrap.
  assign fault_now  = 1'b0;
  assign Fault      = 1'b0;
  assign FaultCause = 2'b00;
  assign FaultAddr  = 32'h0;
  assign unused_ok  = ^{FaultClr, Addr[31:ADDR_W+2]};
`endif

  // Store lane enables and lane-replicated data.
  always_comb begin
    be = 4'hF;
    wd = WriteData;
    case (st_sz)
      SZ_B: begin
        be = 4'(4'b0001 << lane);
        wd = {4{WriteData[7:0]}};
      end
      SZ_H: begin
        be = Addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{WriteData[15:0]}};
      end
      default: begin
        be = 4'hF;
        wd = WriteData;
      end
    endcase
  end

  assign st_en = MemWrite && !fault_now;

  // Array is never reset; a store sampled while reset is low is dropped whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign word   = mem[idx];
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half_v = word[{Addr[1], 4'b0000} +: 16];

  // Combinational load path; pre-write contents are seen during a same-cycle store.
  always_comb begin
    ReadData = 32'h0;
    if (rst_n && MemRead && !fault_now) begin
      case (ld_sz)
        SZ_B:    ReadData = Funct3[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        SZ_H:    ReadData = Funct3[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        default: ReadData = word;
      endcase
    end
  end

endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory stage directly downstream of the ALU in the single-cycle RISC-V datapath. The ALU result is the byte address. The block services RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a word-organised little-endian array. Its read path is combinational so load data reaches writeback in the same cycle. Stores commit on the clock edge, and a sticky fault register captures the first illegal access for the trap logic.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `Addr`, input, 32: byte address, driven from the ALU result.
- `WriteData`, input, 32: store data from register file rs2; the low byte/half is used for SB/SH.
- `MemWrite`, input, 1: store request this cycle.
- `MemRead`, input, 1: load request this cycle.
- `Funct3`, input, 3: access size and signedness, using RV32I funct3 encoding.
- `ReadData`, output, 32: extended load result (combinational).
- `Fault`, output, 1: sticky flag, set when an illegal access has been recorded.
- `FaultCause`, output, 2: 01 = misaligned, 10 = out of range, 11 = illegal Funct3.
- `FaultAddr`, output, 32: `Addr` of the recorded faulting access.
- `FaultClr`, input, 1: clears the sticky fault state on the next edge.

## Operation
- Word index = `Addr[ADDR_W+1:2]`, where `ADDR_W` = log2(`DEPTH_WORDS`). Byte lane = `Addr[1:0]`, little-endian (lane 0 = bits 7:0).
- Loads:
  - 000 LB and 100 LBU: byte at lane `Addr[1:0]`, sign-extended for LB, zero-extended for LBU.
  - 001 LH and 101 LHU: half at `Addr[1]`, sign-extended for LH, zero-extended for LHU.
  - 010 LW: full word.
  - Funct3 011/110/111 are illegal for loads.
- Stores:
  - 000 SB: writes only the addressed byte lane.
  - 001 SH: writes the addressed half.
  - 010 SW: writes all four lanes.
  - Any other Funct3 is illegal for stores.
- Out of range: `Addr` ≥ 4·`DEPTH_WORDS`.
- Misaligned:
  - Half access with `Addr[0]`=1.
  - Word access with `Addr[1:0]` ≠ 00.
- Fault priority for a single access: illegal > out of range > misaligned.
- A faulting access is suppressed:
  - A store writes no byte.
  - A load returns `ReadData` = 0.
- `ReadData` = 0 whenever `MemRead`=0 or `rst_n`=0.
- Sticky capture:
  - If `Fault`=0 and a qualifying access (`MemRead` or `MemWrite`) faults, then `Fault`, `FaultCause` and `FaultAddr` load at the edge.
  - Once set, later faults do not overwrite the captured state.
- `FaultClr`:
  - With no fault that cycle, `FaultClr` clears all three fault outputs to 0.
  - If `FaultClr` and a new fault coincide, the new fault is captured (clear-then-set).
- `MemRead` and `MemWrite` both high to the same word: `ReadData` shows the pre-write contents, and the write commits at the edge.

## Timing
- Load latency 0: `ReadData` is combinational from `Addr`, `Funct3`, `MemRead` and the array.
- Store latency 1: the array updates at the rising edge. A load of the same address in the following cycle returns the new data.
- Fault outputs are registered and visible the cycle after the faulting access.
- Reset values: `Fault`=0, `FaultCause`=00, `FaultAddr`=0x0000_0000, `ReadData`=0.
- Array contents are not reset and are retained across reset.
- While `rst_n`=0 no store commits. Reset asserted mid-store aborts that store entirely; no partial lanes are written.
- Back-to-back stores on consecutive cycles are all committed, with no stall or handshake.

## Configuration
- `DMEM_FAULT_EN` defined: fault detection, access suppression and the sticky fault registers exactly as above.
- `DMEM_FAULT_EN` undefined:
  - No fault state. `Fault`, `FaultCause` and `FaultAddr` are tied to 0, and `FaultClr` is ignored.
  - Addresses are force-aligned (half: `Addr[0]` treated as 0; word: `Addr[1:0]` treated as 00).
  - Out-of-range addresses wrap modulo 4·`DEPTH_WORDS`.
  - Illegal Funct3 values are treated as word accesses.

## Test plan
- Byte stores then word load:
  - SW 0x0000_0000 to addr 0x10, then SB `WriteData`=0xAB to 0x11, then SB 0xCD to 0x13.
  - LW 0x10 must return 0xCD00_AB00.
- Load extension:
  - Store 0x8070_F0FF to 0x20.
  - LB 0x20 → 0xFFFF_FFFF; LBU 0x20 → 0x0000_00FF; LH 0x22 → 0xFFFF_8070; LHU 0x22 → 0x0000_8070; LB 0x21 → 0xFFFF_FFF0.
- Misaligned store (`DMEM_FAULT_EN` defined):
  - SW 0xDEAD_BEEF to 0x22.
  - Memory at 0x20 is unchanged. Next cycle `Fault`=1, `FaultCause`=01, `FaultAddr`=0x22.
- Sticky and clear behaviour:
  - After the case above, LW to 0x400 (out of range, `DEPTH_WORDS`=256): the captured state stays (01, 0x22) and `ReadData`=0.
  - `FaultClr` plus an illegal-Funct3 load (011) in the same cycle: the state becomes (11, that address).
  - `FaultClr` alone: all fault outputs clear to 0.
- Reset mid-store:
  - Assert `rst_n`=0 asynchronously while SW 0x1234_5678 to 0x30 is pending, with the prior contents of 0x30 = 0xAAAA_AAAA.
  - After release, LW 0x30 = 0xAAAA_AAAA and the fault outputs are 0.
- Read-during-write:
  - `MemRead` and `MemWrite` both high for SW 0x5555_5555 to 0x40, whose old value is 0x1111_1111.
  - `ReadData`=0x1111_1111 that cycle, and 0x5555_5555 on the next cycle's LW.
